// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmit scheduler.
//   state_e             - scheduler FSM states (idle / shifting a word / inter-word gap)
//   clog2()             - ceiling log2, never less than 1, for sizing index and counter fields
//   DEFAULT_*           - default word width, requester count and gap length
package serial_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH      = 8;
    localparam int unsigned DEFAULT_NREQ       = 4;
    localparam int unsigned DEFAULT_GAP_CYCLES = 1;

    // Width needed to hold values 0..value-1; a 1-bit floor keeps vectors legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_piso_lsb.sv
// Loadable parallel-in/serial-out shift register, LSB first.
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset, clears the register
//   load      - capture load_data (has priority over shift)
//   shift     - shift right by one with zero fill
//   load_data - parallel word to capture
//   lsb       - current bit 0 of the register
module serial_piso_lsb
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             lsb
);

    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= load_data;
        end else if (shift) begin
            shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    assign lsb = shreg_q[0];

endmodule

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler sharing one serial shift path among NREQ requesters.
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   enable    - permits new arbitration; a frame in progress always completes
//   req       - per-requester request, held with data stable until granted
//   data_in   - requester i word at [i*WIDTH +: WIDTH]
//   grant     - one-hot pulse in the first shift cycle: word captured
//   ser_out   - serial data, LSB first
//   ser_frame - high while ser_out carries a valid bit
//   busy      - high while shifting or in the inter-word gap
//   active_id - index of the requester being shifted; holds its last value
//   word_done - one-cycle pulse in the first gap cycle
module serial_tx_sched
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned NREQ       = DEFAULT_NREQ,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    data_in,
    output logic [NREQ-1:0]          grant,
    output logic                     ser_out,
    output logic                     ser_frame,
    output logic                     busy,
    output logic [clog2(NREQ)-1:0]   active_id,
    output logic                     word_done
);

    localparam int unsigned ID_W    = clog2(NREQ);
    localparam int unsigned CNT_MAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
    localparam int unsigned CNT_W   = clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   active_id_q, active_id_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              done_q, done_d;

    logic              found;
    logic              start;
    logic              shreg_lsb;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    int unsigned       idx;
    logic [WIDTH-1:0]  word_sel;

    // Rotating priority: first set request at or after the pointer, modulo NREQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx  = (32'(ptr_q) + k) % NREQ;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign word_sel = data_in[32'(winner)*WIDTH +: WIDTH];
    assign start    = (state_q == StIdle) && enable && found;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (cnt_q == LAST_BIT) state_d = StGap;
            StGap:   if (cnt_q == LAST_GAP) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: the counter restarts whenever the state changes.
    always_comb begin
        cnt_d       = '0;
        ptr_d       = ptr_q;
        active_id_d = active_id_q;
        grant_d     = '0;
        done_d      = (state_q == StShift) && (cnt_q == LAST_BIT);
        if (state_q != StIdle && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (start) begin
            grant_d     = NREQ'(1) << winner;
            active_id_d = winner;
            ptr_d       = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            ptr_q       <= '0;
            active_id_q <= '0;
            grant_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            active_id_q <= active_id_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
        end
    end

    serial_piso_lsb #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (start),
        .shift     (state_q == StShift),
        .load_data (word_sel),
        .lsb       (shreg_lsb)
    );

    // Outputs, all derived from flops
    always_comb begin
        ser_frame = (state_q == StShift);
        ser_out   = ser_frame & shreg_lsb;
        busy      = (state_q != StIdle);
        grant     = grant_q;
        word_done = done_q;
        active_id = active_id_q;
    end

endmodule

// File: tb/tb_serial_tx_sched.sv
module tb_serial_tx_sched;

    localparam int unsigned W    = 8;
    localparam int unsigned N    = 4;
    localparam int unsigned GAP3 = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   grant;
    logic           ser_out, ser_frame, busy, word_done;
    logic [1:0]     active_id;

    logic           enable_g3 = 1'b0;
    logic [N-1:0]   req_g3 = '0;
    logic [N-1:0]   grant_g3;
    logic           ser_out_g3, ser_frame_g3, busy_g3, word_done_g3;
    logic [1:0]     active_id_g3;
    logic [W-1:0]   g3_word = '0;

    serial_tx_sched #(.WIDTH(W), .NREQ(N), .GAP_CYCLES(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .ser_out   (ser_out),
        .ser_frame (ser_frame),
        .busy      (busy),
        .active_id (active_id),
        .word_done (word_done)
    );

    serial_tx_sched #(.WIDTH(W), .NREQ(N), .GAP_CYCLES(GAP3)) dut_g3 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable_g3),
        .req       (req_g3),
        .data_in   (data_in),
        .grant     (grant_g3),
        .ser_out   (ser_out_g3),
        .ser_frame (ser_frame_g3),
        .busy      (busy_g3),
        .active_id (active_id_g3),
        .word_done (word_done_g3)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int unsigned  id;
        logic [W-1:0] word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic wait_grant(input bit g3, input int id, output int at);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (g3 ? grant_g3[id] : grant[id]) seen = 1'b1;
        end
        at = cycle;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant to %0d (g3=%0d) within 60 cycles", id, g3);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (word_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no word_done within 60 cycles");
        end
    endtask

    // Scoreboard monitor for the GAP=1 instance
    initial begin : monitor
        exp_t         cur;
        int           nbits;
        logic [W-1:0] got;
        bit           in_frame;
        nbits    = 0;
        got      = '0;
        in_frame = 1'b0;
        cur      = '{0, '0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                nbits    = 0;
                in_frame = 1'b0;
                continue;
            end
            if (grant != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("grant_onehot", 32'(grant), 32'd1 << cur.id);
                    chk("active_id", 32'(active_id), cur.id);
                    in_frame = 1'b1;
                    nbits    = 0;
                    got      = '0;
                end
            end
            if (ser_frame) begin
                if (!in_frame || nbits >= int'(W)) begin
                    chk("frame_outside_word", 32'(ser_frame), 32'd0);
                end else begin
                    got   = {ser_out, got[W-1:1]};
                    nbits = nbits + 1;
                    if (nbits == int'(W)) chk("word_bits", 32'(got), 32'(cur.word));
                end
            end
            if (word_done) begin
                chk("done_after_full_frame", nbits, W);
                in_frame = 1'b0;
            end
        end
    end

    // Monitor for the GAP=3 instance: word content and idle-line length between frames
    initial begin : monitor_g3
        int           nbits;
        int           low;
        bit           prev;
        bit           armed;
        logic [W-1:0] got;
        nbits = 0;
        low   = 0;
        prev  = 1'b0;
        armed = 1'b0;
        got   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                nbits = 0;
                prev  = 1'b0;
                armed = 1'b0;
                continue;
            end
            if (ser_frame_g3) begin
                if (!prev) begin
                    if (armed) chk("g3_low_cycles", low, GAP3 + 1);
                    nbits = 0;
                end
                got   = {ser_out_g3, got[W-1:1]};
                nbits = nbits + 1;
                if (nbits == int'(W)) chk("g3_word", 32'(got), 32'(g3_word));
            end else begin
                if (prev) begin
                    armed = 1'b1;
                    low   = 0;
                end
                if (armed) low = low + 1;
            end
            prev = ser_frame_g3;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t;
        int tprev;
        int c0;
        t     = 0;
        tprev = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ser_out", 32'(ser_out), 32'd0);
        chk("rst_ser_frame", 32'(ser_frame), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        chk("rst_word_done", 32'(word_done), 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;

        // 1: single word 0xA5 from requester 0
        data_in[7:0] = 8'hA5;
        sb.push_back('{0, 8'hA5});
        req[0] = 1'b1;
        c0 = cycle;
        wait_grant(1'b0, 0, t);
        req[0] = 1'b0;
        chk("t1_latency", t - c0, 1);
        chk("t1_busy_shift", 32'(busy), 32'd1);
        wait_done();
        chk("t1_busy_gap", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // 2: all four requesting, pointer back at 0
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        data_in = {8'h04, 8'h03, 8'h02, 8'h01};
        for (int k = 0; k < 4; k++) sb.push_back('{k, 8'(k + 1)});
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_grant(1'b0, k, t);
            if (k > 0) chk("t2_period", t - tprev, W + 1 + 1);
            tprev = t;
        end
        req = '0;
        wait_done();
        @(negedge clk);

        // 3: grant to 1, then 0101 resolves to 2 before 0
        data_in[15:8] = 8'h5A;
        sb.push_back('{1, 8'h5A});
        req[1] = 1'b1;
        wait_grant(1'b0, 1, t);
        req[1] = 1'b0;
        data_in[7:0]   = 8'h11;
        data_in[23:16] = 8'h22;
        sb.push_back('{2, 8'h22});
        sb.push_back('{0, 8'h11});
        req = 4'b0101;
        wait_grant(1'b0, 2, t);
        req[2] = 1'b0;
        wait_grant(1'b0, 0, t);
        req[0] = 1'b0;
        wait_done();
        @(negedge clk);

        // 4: reset during bit 3, then a fresh frame
        data_in[7:0] = 8'h0F;
        sb.push_back('{0, 8'h0F});
        req[0] = 1'b1;
        wait_grant(1'b0, 0, t);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_bit3_value", 32'(ser_out), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t4_async_ser_out", 32'(ser_out), 32'd0);
        chk("t4_async_ser_frame", 32'(ser_frame), 32'd0);
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_grant", 32'(grant), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        data_in[7:0] = 8'h3C;
        sb.push_back('{0, 8'h3C});
        req[0] = 1'b1;
        wait_grant(1'b0, 0, t);
        req[0] = 1'b0;
        wait_done();
        @(negedge clk);

        // 5: enable gating
        enable        = 1'b0;
        data_in[15:8] = 8'h96;
        req           = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_grant_disabled", 32'(grant), 32'd0);
            chk("t5_idle_disabled", 32'(busy), 32'd0);
        end
        sb.push_back('{1, 8'h96});
        enable = 1'b1;
        @(negedge clk);
        chk("t5_grant_on_enable", 32'(grant), 32'b0010);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_done();
        @(negedge clk);
        chk("t5_parked", 32'(busy), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t5_no_regrant", 32'(grant), 32'd0);
        end
        req    = '0;
        enable = 1'b1;

        // 6: GAP_CYCLES=3 instance, requester 3 held
        g3_word        = 8'h81;
        data_in[31:24] = 8'h81;
        enable_g3      = 1'b1;
        req_g3         = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            wait_grant(1'b1, 3, t);
            if (k > 0) chk("t6_period", t - tprev, W + GAP3 + 1);
            tprev = t;
        end
        req_g3 = '0;
        repeat (20) @(negedge clk);
        chk("t6_idle_after", 32'(busy_g3), 32'd0);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_sched.md
Name: serial_tx_sched

Overview:
- Round-robin scheduler that shares one parallel-in/serial-out shift path among NREQ requesters.
- Grants one requester at a time and captures its WIDTH-bit word.
- Shifts the word out LSB first, one bit per clk rising edge, with a framing strobe, then inserts an inter-word gap.
- Sits between front-end word producers and the serial output line; it sequences the shift datapath rather than free-running it.

Parameters:
- WIDTH, 8, bits per serialized word; must be ≥2.
- NREQ, 4, number of requesters; must be ≥2.
- GAP_CYCLES, 1, idle line cycles after each word; must be ≥1.

Ports:
- clk  input  1  sole clock; all state changes on rising edge only.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  high permits new arbitration; does not abort a frame in progress.
- req  input  NREQ  per-requester request; held high with data stable until grant seen.
- data_in  input  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot, one-cycle pulse: word captured.
- ser_out  output  1  serial data, LSB first.
- ser_frame  output  1  high while ser_out carries a valid bit.
- busy  output  1  high in SHIFT or GAP.
- active_id  output  clog2(NREQ)  index of requester being shifted; holds last value otherwise.
- word_done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, round-robin pointer 0, bit counter 0, shift register 0. Any in-flight word is discarded. Leaving reset is synchronous to the next rising edge.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - On an edge with enable=1 and any req bit high, pick the winner: first set req bit at or after the pointer, scanning upward modulo NREQ.
  - On that same edge: load data_in slice into the shift register, grant[winner]=1, active_id=winner, pointer=(winner+1) mod NREQ, bit count=0, go to SHIFT.
  - With enable=0 or no req bit high, stay in IDLE with all pulses 0.
- SHIFT:
  - ser_frame=1 and ser_out=shreg[0], both registered.
  - Each edge shifts right with zero fill and increments the count.
  - grant is high only in the first SHIFT cycle.
  - After WIDTH cycles in SHIFT, go to GAP.
- GAP:
  - ser_frame=0 and ser_out=0.
  - word_done=1 in the first GAP cycle only.
  - Stay GAP_CYCLES cycles, then go to IDLE.
- Latency:
  - req seen in IDLE → first bit valid on ser_out 1 cycle later.
  - Back-to-back frames start every WIDTH+GAP_CYCLES+1 cycles, including 1 IDLE arbitration cycle.
- Requester rule: drop req on the edge after grant is seen, or keep it high to request the next word. req held high is never re-granted before the next IDLE.
- Simultaneous requests: exactly one grant per word; grant is never multi-hot.
- enable falling mid-frame: the current frame and gap complete; the block then parks in IDLE.
- Wrap-around: pointer wraps NREQ-1 → 0; bit counter wraps only via the state change.
- Word content is never altered: output bits equal captured bits 0..WIDTH-1 in order.

Decomposition:
- Shared package serial_tx_pkg:
  - state enumeration (IDLE, SHIFT, GAP);
  - clog2 constant function;
  - default WIDTH and GAP constants.
- Sub-module serial_piso_lsb:
  - WIDTH-bit loadable shift register with load, shift enable, registered LSB output and zero fill.
  - Instantiated once; the scheduler FSM, arbiter and counters stay in the top module.

Test Plan:
1. NREQ=4, WIDTH=8, GAP=1; req[0]=1 with data 0xA5 → grant=4'b0001 for one cycle; ser_out=1,0,1,0,0,1,0,1 over 8 ser_frame cycles; then word_done pulse and busy low 1 cycle later.
2. req=4'b1111 held, words 0x01/0x02/0x03/0x04 → grants in order 0,1,2,3, one per 10 cycles; active_id=0,1,2,3; serial stream reproduces each word LSB first.
3. After a grant to 1, raise req=4'b0101 → requester 2 granted first, then requester 0.
4. reset low during bit 3 of a frame → ser_out, ser_frame, busy, grant drop to 0 immediately without a clock. After release with req[0]=1 and data 0x3C → fresh grant to 0 and a complete 8-bit frame.
5. enable=0 with req=4'b0010 for 5 cycles → no grant, busy=0; enable=1 → grant[1] on next edge. enable=0 at bit 2 → frame and gap complete, then no new grant.
6. GAP_CYCLES=3, req[3] held high → frames start every 12 cycles; ser_frame low exactly 4 cycles between frames.
